mem_ram_boot: RTL and testbench
===============================

// Module: mem_ram_boot
// PURPOSE
//   Parametrised single-port synchronous data RAM with a built-in init sequencer.
//   - Fills every word with FILL_VALUE after reset and on request.
//   - Accepts a streamed boot image over a valid/ready load port, replacing testbench-only preloading.
//   - Sits between the processor datapath (D/Address/WE/RE/Q) and the boot/loader logic.
// PARAMETERS
//   DATA_W      8    word width in bits
//   ADDR_W      5    address width; DEPTH = 2**ADDR_W words (localparam)
//   FILL_VALUE  0    DATA_W-bit value written to every word by the clear sweep
// PORTS
//   CLOCK       in   1         rising-edge clock
//   RESET       in   1         asynchronous, active-high reset
//   D           in   DATA_W    write data
//   Address     in   ADDR_W    read/write address
//   WE          in   1         write enable
//   RE          in   1         read enable
//   Q           out  DATA_W    registered read data
//   Q_VALID     out  1         one-cycle pulse: Q updated this cycle
//   INIT_REQ    in   1         pulse: start a clear sweep
//   LOAD_START  in   1         pulse: start a boot-image load at address 0
//   LOAD_VALID  in   1         load beat valid
//   LOAD_DATA   in   DATA_W    load beat data
//   LOAD_LAST   in   1         final beat of the image (qualified by LOAD_VALID)
//   LOAD_READY  out  1         RAM accepts a load beat this cycle
//   LOAD_COUNT  out  ADDR_W+1  beats written by the current/last load
//   LOAD_OVF    out  1         sticky: image filled DEPTH words without LOAD_LAST
//   BUSY        out  1         state != IDLE; CPU port ignored
// BEHAVIOUR
//   Reset (async) values
//   - state=CLEAR, ptr=0, Q=0, Q_VALID=0, LOAD_READY=0, LOAD_COUNT=0, LOAD_OVF=0, BUSY=1.
//   - Memory array is not reset; contents are defined only once the sweep completes.
//   FSM states: CLEAR, IDLE, LOAD.
//   CLEAR
//   - Each cycle writes mem[ptr]=FILL_VALUE, then ptr++.
//   - The write at ptr=DEPTH-1 moves to IDLE, so the sweep takes exactly DEPTH cycles after reset release.
//   - LOAD_START is ignored. INIT_REQ restarts the sweep with ptr=0.
//   IDLE (BUSY=0)
//   - WE=1: mem[Address]<=D. Q holds; Q_VALID=0.
//   - WE=0, RE=1: Q<=mem[Address] at the edge; Q_VALID=1 for that one cycle (1-cycle latency).
//   - WE=1 and RE=1: the write wins and no read occurs.
//   - Neither WE nor RE: Q holds; Q_VALID=0.
//   - INIT_REQ -> CLEAR with ptr=0. LOAD_START -> LOAD with ptr=0, LOAD_COUNT=0, LOAD_OVF=0.
//   - INIT_REQ and LOAD_START in the same cycle: INIT_REQ wins.
//   LOAD
//   - LOAD_READY=1 combinationally while in LOAD.
//   - Beat accepted when LOAD_VALID=1: mem[ptr]<=LOAD_DATA, ptr++, LOAD_COUNT++.
//   - Accepted beat with LOAD_LAST=1 -> IDLE.
//   - Accepted beat at ptr=DEPTH-1 -> IDLE. If LOAD_LAST=0 on that beat, LOAD_OVF<=1; the RAM takes no more beats.
//   - INIT_REQ aborts the load -> CLEAR. LOAD_COUNT keeps the partial count.
//   Busy rules
//   - While BUSY, WE/RE are ignored: no write, Q holds, Q_VALID=0.
//   - LOAD_READY=0 outside LOAD.
//   Address wrap: ptr is ADDR_W bits and never wraps inside one sweep or load; LOAD_COUNT max = DEPTH.
//   RESET mid-load or mid-sweep: immediate return to CLEAR with ptr=0; partial image is discarded by the sweep.
// TESTING
//   1. Release RESET; count BUSY-high cycles.
//      -> BUSY high exactly 32 cycles (DEPTH=32); then RE at all 32 addresses returns 8'h00, each with Q_VALID one cycle later.
//   2. IDLE: WE=1, Address=5'h07, D=8'hCC; next cycle RE at 5'h07.
//      -> Q=8'hCC, Q_VALID pulse. WE=1 and RE=1 at 5'h07 with D=8'h11 -> Q_VALID=0, later read returns 8'h11.
//   3. LOAD_START, then 4 beats 8'h80,8'h3E,8'h80,8'h3F with LOAD_LAST on beat 4 and LOAD_VALID gapped on alternate cycles.
//      -> LOAD_COUNT=4, LOAD_OVF=0; addresses 0..3 read back those bytes; address 4 reads FILL_VALUE.
//   4. Load 32 beats with no LOAD_LAST.
//      -> IDLE after beat 32, LOAD_OVF=1, LOAD_COUNT=32, LOAD_READY=0.
//      -> A subsequent LOAD_START clears LOAD_OVF.
//   5. INIT_REQ during a load after 3 beats.
//      -> BUSY stays 1 for 32 more cycles, LOAD_COUNT=3, all words read 8'h00.
//      -> WE pulses issued while BUSY leave memory unchanged.
//   6. Assert RESET mid-sweep (ptr=10) for 1 cycle.
//      -> Outputs go to reset values immediately; the sweep restarts; BUSY high 32 cycles after release.

Source files
------------

// File: rtl/mem_ram_boot.sv
// Single-port synchronous data RAM with a power-on/requested clear sweep and a
// streamed boot-image loader. The CPU port is only serviced while the sequencer is idle.
module mem_ram_boot #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 5,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] Address,
  input  logic              WE,
  input  logic              RE,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  input  logic              INIT_REQ,
  input  logic              LOAD_START,
  input  logic              LOAD_VALID,
  input  logic [DATA_W-1:0] LOAD_DATA,
  input  logic              LOAD_LAST,
  output logic              LOAD_READY,
  output logic [ADDR_W:0]   LOAD_COUNT,
  output logic              LOAD_OVF,
  output logic              BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] PtrLast  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_d;
  logic [ADDR_W:0]     r_load_count, w_load_count_d;
  logic                r_load_ovf, w_load_ovf_d;
  logic [DATA_W-1:0]   r_q;
  logic                r_q_valid;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_rd_en;
  logic                w_load_ready;

  always_comb begin
    w_state_d       = r_state;
    w_ptr_d         = r_ptr;
    w_load_count_d  = r_load_count;
    w_load_ovf_d    = r_load_ovf;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_ptr;
    w_mem_wdata     = FILL_VALUE;
    w_rd_en         = 1'b0;
    w_load_ready    = 1'b0;

    unique case (r_state)
      StClear: begin
        w_mem_we = 1'b1;
        if (INIT_REQ) begin
          w_ptr_d = '0;
        end else if (r_ptr == PtrLast) begin
          w_state_d = StIdle;
          w_ptr_d   = '0;
        end else begin
          w_ptr_d = r_ptr + PtrOne;
        end
      end

      StIdle: begin
        // A simultaneous write suppresses the read.
        if (WE) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = Address;
          w_mem_wdata = D;
        end else if (RE) begin
          w_rd_en = 1'b1;
        end
        if (INIT_REQ) begin
          w_state_d = StClear;
          w_ptr_d   = '0;
        end else if (LOAD_START) begin
          w_state_d      = StLoad;
          w_ptr_d        = '0;
          w_load_count_d = '0;
          w_load_ovf_d   = 1'b0;
        end
      end

      StLoad: begin
        w_load_ready = 1'b1;
        // An abort takes priority over a beat presented in the same cycle.
        if (INIT_REQ) begin
          w_state_d = StClear;
          w_ptr_d   = '0;
        end else if (LOAD_VALID) begin
          w_mem_we       = 1'b1;
          w_mem_wdata    = LOAD_DATA;
          w_load_count_d = r_load_count + CountOne;
          if (LOAD_LAST || (r_ptr == PtrLast)) begin
            w_state_d    = StIdle;
            w_ptr_d      = '0;
            w_load_ovf_d = ~LOAD_LAST;
          end else begin
            w_ptr_d = r_ptr + PtrOne;
          end
        end
      end

      default: w_state_d = StClear;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= StClear;
      r_ptr        <= '0;
      r_load_count <= '0;
      r_load_ovf   <= 1'b0;
      r_q          <= '0;
      r_q_valid    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ptr        <= w_ptr_d;
      r_load_count <= w_load_count_d;
      r_load_ovf   <= w_load_ovf_d;
      r_q_valid    <= w_rd_en;
      if (w_rd_en) r_q <= r_mem[Address];
    end
  end

  // Storage is deliberately unreset; the clear sweep defines its contents.
  always_ff @(posedge CLOCK) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign Q          = r_q;
  assign Q_VALID    = r_q_valid;
  assign LOAD_READY = w_load_ready;
  assign LOAD_COUNT = r_load_count;
  assign LOAD_OVF   = r_load_ovf;
  assign BUSY       = (r_state != StIdle);

endmodule

// File: tb/tb_mem_ram_boot.sv
// Directed plus randomized bench for mem_ram_boot; expectations come from a
// word-array model of the RAM and the documented sweep/load rules.
module tb_mem_ram_boot;

  localparam int DEPTH = 32;

  typedef logic [7:0] byte_q_t [$];

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] D = '0;
  logic [4:0] Address = '0;
  logic       WE = 1'b0;
  logic       RE = 1'b0;
  logic [7:0] Q;
  logic       Q_VALID;
  logic       INIT_REQ = 1'b0;
  logic       LOAD_START = 1'b0;
  logic       LOAD_VALID = 1'b0;
  logic [7:0] LOAD_DATA = '0;
  logic       LOAD_LAST = 1'b0;
  logic       LOAD_READY;
  logic [5:0] LOAD_COUNT;
  logic       LOAD_OVF;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_q;

  mem_ram_boot #(
    .DATA_W     (8),
    .ADDR_W     (5),
    .FILL_VALUE (8'h00)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .D          (D),
    .Address    (Address),
    .WE         (WE),
    .RE         (RE),
    .Q          (Q),
    .Q_VALID    (Q_VALID),
    .INIT_REQ   (INIT_REQ),
    .LOAD_START (LOAD_START),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_LAST  (LOAD_LAST),
    .LOAD_READY (LOAD_READY),
    .LOAD_COUNT (LOAD_COUNT),
    .LOAD_OVF   (LOAD_OVF),
    .BUSY       (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  // Counts busy cycles; optionally hammers the CPU port meanwhile.
  task automatic wait_idle(input bit noise, output int n, output bit qv_seen);
    n = 0;
    qv_seen = 1'b0;
    while (BUSY === 1'b1 && n < 200) begin
      if (noise) begin
        WE = n[0];
        RE = ~n[0];
        Address = 5'd0;
        D = 8'h5A;
      end
      tick();
      n++;
      if (Q_VALID === 1'b1) qv_seen = 1'b1;
    end
    WE = 1'b0;
    RE = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a);
    Address = a;
    RE = 1'b1;
    WE = 1'b0;
    tick();
    RE = 1'b0;
    check($sformatf("rd_q[%0d]", a), Q, model_mem[a]);
    check("rd_qvalid", Q_VALID, 1);
    model_q = model_mem[a];
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    Address = a;
    D = d;
    WE = 1'b1;
    RE = 1'b0;
    tick();
    WE = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) cpu_read(5'(i));
  endtask

  task automatic load_image(input byte_q_t img, input bit with_last, input bit gapped);
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    check("load_ready_on_start", LOAD_READY, 1);
    for (int i = 0; i < img.size(); i++) begin
      if (gapped && i > 0) begin
        LOAD_VALID = 1'b0;
        tick();
      end
      LOAD_VALID = 1'b1;
      LOAD_DATA  = img[i];
      LOAD_LAST  = with_last && (i == img.size() - 1);
      tick();
      if (i < DEPTH) model_mem[i] = img[i];
    end
    LOAD_VALID = 1'b0;
    LOAD_LAST  = 1'b0;
  endtask

  initial begin
    int      n;
    bit      qv;
    byte_q_t img;
    int      len;
    bit      gap;

    // 1. Reset values, sweep length, cleared contents
    tick();
    tick();
    check("rst_busy", BUSY, 1);
    check("rst_q", Q, 0);
    check("rst_qvalid", Q_VALID, 0);
    check("rst_ready", LOAD_READY, 0);
    check("rst_count", LOAD_COUNT, 0);
    check("rst_ovf", LOAD_OVF, 0);
    RESET = 1'b0;
    wait_idle(1'b0, n, qv);
    check("sweep_cycles", n, DEPTH);
    fill_model();
    read_all();
    tick();
    check("qvalid_one_cycle", Q_VALID, 0);

    // 2. Write/read and write-wins collision
    cpu_write(5'h07, 8'hCC);
    check("wr_no_qvalid", Q_VALID, 0);
    cpu_read(5'h07);
    Address = 5'h07;
    D = 8'h11;
    WE = 1'b1;
    RE = 1'b1;
    tick();
    WE = 1'b0;
    RE = 1'b0;
    model_mem[7] = 8'h11;
    check("collide_qvalid", Q_VALID, 0);
    check("collide_q_hold", Q, model_q);
    cpu_read(5'h07);

    // 3. Gapped 4-beat image
    img = '{8'h80, 8'h3E, 8'h80, 8'h3F};
    load_image(img, 1'b1, 1'b1);
    check("img4_count", LOAD_COUNT, 4);
    check("img4_ovf", LOAD_OVF, 0);
    check("img4_busy", BUSY, 0);
    for (int i = 0; i < 5; i++) cpu_read(5'(i));

    // 4. Overflowing image, then a fresh load clears the flag
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(8'($urandom));
    load_image(img, 1'b0, 1'b0);
    check("ovf_flag", LOAD_OVF, 1);
    check("ovf_count", LOAD_COUNT, DEPTH);
    check("ovf_ready", LOAD_READY, 0);
    check("ovf_busy", BUSY, 0);
    read_all();
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    check("restart_ovf_clr", LOAD_OVF, 0);
    check("restart_count_clr", LOAD_COUNT, 0);
    LOAD_VALID = 1'b1;
    LOAD_DATA = 8'h42;
    LOAD_LAST = 1'b1;
    tick();
    LOAD_VALID = 1'b0;
    LOAD_LAST = 1'b0;
    model_mem[0] = 8'h42;
    check("restart_count", LOAD_COUNT, 1);

    // Random-length images with random gapping
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, DEPTH);
      gap = 1'($urandom);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      load_image(img, 1'b1, gap);
      check("rand_load_count", LOAD_COUNT, len);
      check("rand_load_ovf", LOAD_OVF, 0);
      check("rand_load_busy", BUSY, 0);
      read_all();
    end

    // 5. Abort after 3 beats; CPU writes while busy must be ignored
    img = '{8'hA1, 8'hB2, 8'hC3};
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA = img[i];
      tick();
    end
    LOAD_VALID = 1'b0;
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    check("abort_ready", LOAD_READY, 0);
    wait_idle(1'b1, n, qv);
    check("abort_sweep_cycles", n, DEPTH);
    check("abort_count", LOAD_COUNT, 3);
    check("busy_no_qvalid", qv, 0);
    fill_model();
    read_all();

    // Random CPU traffic
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 1) == 1) cpu_write(5'($urandom), 8'($urandom));
      else cpu_read(5'($urandom));
    end

    // 6. Reset in the middle of a sweep
    cpu_write(5'd3, 8'hA5);
    cpu_read(5'd3);
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RESET = 1'b1;
    #1;
    check("midrst_busy", BUSY, 1);
    check("midrst_q", Q, 0);
    check("midrst_qvalid", Q_VALID, 0);
    check("midrst_count", LOAD_COUNT, 0);
    check("midrst_ovf", LOAD_OVF, 0);
    check("midrst_ready", LOAD_READY, 0);
    tick();
    RESET = 1'b0;
    wait_idle(1'b0, n, qv);
    check("midrst_sweep_cycles", n, DEPTH);
    fill_model();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
